// File: rtl/ika2151.sv
// ika2151: host-bus front end and timing core of the IKA2151 FM synthesizer.
// Derives phi1, runs the 32-slot cycle counter, and owns the register file and busy flag.
`default_nettype none

module ika2151 #(
   parameter int BUSY_CYCLES = 64
) (
   input  logic       i_EMUCLK,
   input  logic       i_IC,
   input  logic       i_phiM_PCEN_n,
   output logic       o_phi1,
   input  logic       i_CS_n,
   input  logic       i_RD_n,
   input  logic       i_WR_n,
   input  logic       i_A0,
   input  logic [7:0] i_D,
   output logic [7:0] o_D,
   output logic       o_CTRL_OE_n,
   output logic       o_SH1,
   output logic       o_SH2,
   input  logic [7:0] i_DBG_ADDR,
   output logic [7:0] o_DBG_DATA
);

   localparam int BW = $clog2(BUSY_CYCLES + 1);

   logic          phi1;
   logic [4:0]    cycle_cnt;
   logic          phi1_rise;
   logic [1:0]    cs_sync;
   logic [1:0]    wr_sync;
   logic [1:0]    rd_sync;
   logic [1:0]    a0_sync;
   logic [7:0]    d_sync0;
   logic [7:0]    d_sync1;
   logic          wr_active;
   logic          wr_prev;
   logic          wr_take;
   logic          rd_active;
   logic [7:0]    addr_latch;
   logic          busy;
   logic [BW-1:0] busy_cnt;
   logic [7:0]    regs [256];

   assign phi1_rise = ~i_phiM_PCEN_n & ~phi1;

   always_ff @(posedge i_EMUCLK) begin
      if (i_IC) begin
         phi1      <= 1'b0;
         cycle_cnt <= 5'd0;
         o_SH1     <= 1'b0;
         o_SH2     <= 1'b0;
      end else begin
         if (!i_phiM_PCEN_n) phi1 <= ~phi1;
         if (phi1_rise) cycle_cnt <= cycle_cnt + 5'd1;
         o_SH1 <= (cycle_cnt[4:3] == 2'b00);
         o_SH2 <= (cycle_cnt[4:3] == 2'b10);
      end
   end

   // Write strobe chain resets to "asserted" so a strobe held across reset release
   // never looks like a fresh rising edge; the read chain resets to idle.
   always_ff @(posedge i_EMUCLK) begin
      if (i_IC) begin
         cs_sync <= 2'b00;
         wr_sync <= 2'b00;
         rd_sync <= 2'b11;
         a0_sync <= 2'b00;
         d_sync0 <= 8'h00;
         d_sync1 <= 8'h00;
         wr_prev <= 1'b1;
      end else begin
         cs_sync <= {cs_sync[0], i_CS_n};
         wr_sync <= {wr_sync[0], i_WR_n};
         rd_sync <= {rd_sync[0], i_RD_n};
         a0_sync <= {a0_sync[0], i_A0};
         d_sync0 <= i_D;
         d_sync1 <= d_sync0;
         wr_prev <= wr_active;
      end
   end

   assign wr_active = ~cs_sync[1] & ~wr_sync[1];
   assign rd_active = ~cs_sync[1] & ~rd_sync[1];
   assign wr_take   = wr_active & ~wr_prev;

   always_ff @(posedge i_EMUCLK) begin
      if (i_IC) begin
         addr_latch <= 8'h00;
         busy       <= 1'b0;
         busy_cnt   <= '0;
         for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      end else begin
         if (wr_take && !a0_sync[1]) addr_latch <= d_sync1;
         if (wr_take && a0_sync[1] && !busy) begin
            regs[addr_latch] <= d_sync1;
            busy             <= 1'b1;
            busy_cnt         <= BUSY_CYCLES[BW-1:0];
         end else if (busy && phi1_rise) begin
            if (busy_cnt == BW'(1)) begin
               busy     <= 1'b0;
               busy_cnt <= '0;
            end else begin
               busy_cnt <= busy_cnt - BW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_IC)           o_D <= 8'h00;
      else if (rd_active) o_D <= {busy, 7'b000_0000};
   end

   assign o_phi1      = phi1;
   assign o_CTRL_OE_n = ~rd_active;
   assign o_DBG_DATA  = regs[i_DBG_ADDR];

endmodule

`default_nettype wire

// File: tb/tb_ika2151.sv
// tb_ika2151: scoreboard bench for the ika2151 bus front end and timing core.
`default_nettype none

module tb_ika2151;

   logic       clk = 1'b0;
   logic       ic = 1'b1;
   logic       pcen_n = 1'b1;
   logic       cs_n = 1'b1;
   logic       rd_n = 1'b1;
   logic       wr_n = 1'b1;
   logic       a0 = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] dbg_addr = 8'h00;
   logic       phi1;
   logic [7:0] dout;
   logic       oe_n;
   logic       sh1;
   logic       sh2;
   logic [7:0] dbg_data;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } sb_t;

   sb_t        sb[$];
   logic [7:0] model [256];
   int         vectors = 0;
   int         miscompares = 0;

   ika2151 #(.BUSY_CYCLES(64)) dut (
      .i_EMUCLK      (clk),
      .i_IC          (ic),
      .i_phiM_PCEN_n (pcen_n),
      .o_phi1        (phi1),
      .i_CS_n        (cs_n),
      .i_RD_n        (rd_n),
      .i_WR_n        (wr_n),
      .i_A0          (a0),
      .i_D           (d),
      .o_D           (dout),
      .o_CTRL_OE_n   (oe_n),
      .o_SH1         (sh1),
      .o_SH2         (sh2),
      .i_DBG_ADDR    (dbg_addr),
      .o_DBG_DATA    (dbg_data)
   );

   always #5 clk = ~clk;

   // phiM enable on every 4th clock
   initial begin
      int pc;
      pc = 0;
      forever begin
         @(negedge clk);
         pc = (pc + 1) % 4;
         pcen_n = (pc == 0) ? 1'b0 : 1'b1;
      end
   end

   task automatic bus_write(input logic sel, input logic [7:0] val, input int len);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; a0 = sel; d = val;
      repeat (len) @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic write_reg(input logic [7:0] addr, input logic [7:0] val, input logic stored);
      bus_write(1'b0, addr, 4);
      bus_write(1'b1, val, 4);
      if (stored) model[addr] = val;
      sb.push_back('{addr: addr, data: model[addr]});
   endtask

   task automatic read_status(output logic [7:0] val, output logic oe);
      @(negedge clk);
      cs_n = 1'b0; rd_n = 1'b0;
      repeat (4) @(negedge clk);
      val = dout; oe = oe_n;
      cs_n = 1'b1; rd_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
   endtask

   task automatic test_reset();
      int last_t, bad_int, toggles, fall_t, sh2_t;
      logic p_phi1, p_sh1, p_sh2;
      int sh1_rise[$];
      int sh1_fall[$];
      int sh2_rise[$];
      ic = 1'b1;
      clear_model();
      repeat (10) @(negedge clk);
      vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", dout); end
      vectors++; if (oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
      vectors++; if (phi1 !== 1'b0) begin miscompares++; $display("FAIL reset_phi1: got %b want 0", phi1); end
      vectors++; if ({sh1, sh2} !== 2'b00) begin miscompares++; $display("FAIL reset_sh: got %b want 00", {sh1, sh2}); end
      ic = 1'b0;
      last_t = -1; bad_int = 0; toggles = 0;
      p_phi1 = phi1; p_sh1 = sh1; p_sh2 = sh2;
      for (int i = 1; i <= 800; i++) begin
         @(negedge clk);
         if (phi1 !== p_phi1) begin
            if (last_t >= 0 && (i - last_t) != 4) bad_int++;
            last_t = i;
            toggles++;
         end
         if (sh1 && !p_sh1) sh1_rise.push_back(i);
         if (!sh1 && p_sh1) sh1_fall.push_back(i);
         if (sh2 && !p_sh2) sh2_rise.push_back(i);
         p_phi1 = phi1; p_sh1 = sh1; p_sh2 = sh2;
      end
      vectors++;
      if (bad_int != 0 || toggles < 190) begin
         miscompares++;
         $display("FAIL phi1_period: got %0d bad intervals in %0d toggles want 0 bad", bad_int, toggles);
      end
      vectors++;
      if (sh1_rise.size() < 3) begin
         miscompares++;
         $display("FAIL sh1_rises: got %0d want >=3", sh1_rise.size());
      end else begin
         fall_t = -1; sh2_t = -1;
         foreach (sh1_fall[k]) if (fall_t < 0 && sh1_fall[k] > sh1_rise[1]) fall_t = sh1_fall[k];
         foreach (sh2_rise[k]) if (sh2_t < 0 && sh2_rise[k] > sh1_rise[1]) sh2_t = sh2_rise[k];
         vectors++;
         if (fall_t - sh1_rise[1] != 64) begin
            miscompares++; $display("FAIL sh1_width: got %0d clocks want 64", fall_t - sh1_rise[1]);
         end
         vectors++;
         if (sh1_rise[2] - sh1_rise[1] != 256) begin
            miscompares++; $display("FAIL sh1_period: got %0d clocks want 256", sh1_rise[2] - sh1_rise[1]);
         end
         vectors++;
         if (sh2_t - sh1_rise[1] != 128) begin
            miscompares++; $display("FAIL sh2_offset: got %0d clocks want 128", sh2_t - sh1_rise[1]);
         end
      end
   endtask

   task automatic test_single_write();
      logic [7:0] st;
      logic       oe;
      bus_write(1'b0, 8'h18, 20);
      bus_write(1'b1, 8'hFF, 20);
      model[8'h18] = 8'hFF;
      read_status(st, oe);
      vectors++; if (st !== 8'h80) begin miscompares++; $display("FAIL busy_after_write: got %h want 80", st); end
      vectors++; if (oe !== 1'b0) begin miscompares++; $display("FAIL read_oe_n: got %b want 0", oe); end
      vectors++; if (oe_n !== 1'b1) begin miscompares++; $display("FAIL idle_oe_n: got %b want 1", oe_n); end
      dbg_addr = 8'h18; #1;
      vectors++; if (dbg_data !== 8'hFF) begin miscompares++; $display("FAIL dbg_18: got %h want FF", dbg_data); end
      dbg_addr = 8'h19; #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL dbg_19: got %h want 00", dbg_data); end
      repeat (600) @(negedge clk);
   endtask

   task automatic test_status_read();
      int clear_t;
      bus_write(1'b0, 8'h20, 4);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; a0 = 1'b1; d = 8'h55;
      model[8'h20] = 8'h55;
      clear_t = -1;
      for (int i = 1; i <= 1000 && clear_t < 0; i++) begin
         @(negedge clk);
         if (i == 4) wr_n = 1'b1;
         if (i == 6) begin
            vectors++; if (dout !== 8'h80) begin miscompares++; $display("FAIL status_busy: got %h want 80", dout); end
            vectors++; if (oe_n !== 1'b0) begin miscompares++; $display("FAIL status_oe_n: got %b want 0", oe_n); end
         end
         if (i > 6 && dout === 8'h00) clear_t = i;
      end
      cs_n = 1'b1; rd_n = 1'b1;
      vectors++;
      if (clear_t < 500 || clear_t > 525) begin
         miscompares++; $display("FAIL busy_duration: got %0d clocks want 500..525", clear_t);
      end
      dbg_addr = 8'h20; #1;
      vectors++; if (dbg_data !== 8'h55) begin miscompares++; $display("FAIL rw_together: got %h want 55", dbg_data); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_busy_drop();
      sb_t e;
      write_reg(8'h28, 8'h3A, 1'b1);
      write_reg(8'h38, 8'h10, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         dbg_addr = e.addr; #1;
         vectors++;
         if (dbg_data !== e.data) begin
            miscompares++; $display("FAIL busy_drop reg %h: got %h want %h", e.addr, dbg_data, e.data);
         end
      end
      repeat (600) @(negedge clk);
      write_reg(8'h38, 8'h10, 1'b1);
      e = sb.pop_front();
      dbg_addr = e.addr; #1;
      vectors++;
      if (dbg_data !== e.data) begin
         miscompares++; $display("FAIL after_busy reg %h: got %h want %h", e.addr, dbg_data, e.data);
      end
      repeat (600) @(negedge clk);
   endtask

   task automatic test_sequence();
      sb_t        e;
      logic [7:0] addrs [9];
      logic [7:0] vals  [9];
      addrs = '{8'hC0, 8'hC8, 8'hD0, 8'hD8, 8'h80, 8'hA0, 8'hE0, 8'h60, 8'h08};
      vals  = '{8'h1F, 8'h40, 8'h80, 8'hC0, 8'h15, 8'h18, 8'hAF, 8'h7F, 8'h08};
      for (int i = 0; i < 9; i++) begin
         write_reg(addrs[i], vals[i], 1'b1);
         repeat (600) @(negedge clk);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         dbg_addr = e.addr; #1;
         vectors++;
         if (dbg_data !== e.data) begin
            miscompares++; $display("FAIL seq reg %h: got %h want %h", e.addr, dbg_data, e.data);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] st;
      logic       oe;
      sb_t        e;
      write_reg(8'h40, 8'h99, 1'b1);
      void'(sb.pop_front());
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d = 8'h77;
      @(negedge clk);
      ic = 1'b1;
      clear_model();
      repeat (5) @(negedge clk);
      ic = 1'b0;
      repeat (10) @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      repeat (4) @(negedge clk);
      dbg_addr = 8'h40; #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset_clear_40: got %h want 00", dbg_data); end
      dbg_addr = 8'h00; #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL held_strobe_00: got %h want 00", dbg_data); end
      dbg_addr = 8'hC0; #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset_clear_C0: got %h want 00", dbg_data); end
      read_status(st, oe);
      vectors++; if (st !== 8'h00) begin miscompares++; $display("FAIL busy_after_reset: got %h want 00", st); end
      write_reg(8'h50, 8'h12, 1'b1);
      e = sb.pop_front();
      dbg_addr = e.addr; #1;
      vectors++;
      if (dbg_data !== e.data) begin
         miscompares++; $display("FAIL post_reset reg %h: got %h want %h", e.addr, dbg_data, e.data);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_status_read();
      test_busy_drop();
      test_sequence();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
